// File: rtl/icache_refill_ctrl_pkg.sv
// Shared geometry constants and controller state type for the I-cache refill sequencer.
// Line geometry is fixed by the cache: 4 words of 32 bits, 16-byte lines.
package icache_refill_ctrl_pkg;

    localparam int unsigned CACHE_WORD_W     = 32;
    localparam int unsigned CACHE_LINE_WORDS = 4;
    localparam int unsigned CACHE_LINE_LEN   = 16;
    localparam int unsigned CACHE_LINE_OFF   = 4;
    localparam int unsigned BEAT_W           = 2;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StFill  = 2'd2
    } state_e;

endpackage

// File: rtl/icache_refill_ctrl_line_assembler.sv
// Collects refill beats into a full cache line; each strobed word lands in the
// slot selected by its beat index, and the other slots keep their contents.
module icache_refill_ctrl_line_assembler
    import icache_refill_ctrl_pkg::*;
#(
    parameter int unsigned LINE_W = 128
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [BEAT_W-1:0]       beat_i,
    input  logic                    strobe_i,
    input  logic [CACHE_WORD_W-1:0] data_i,
    output logic [LINE_W-1:0]       line_o
);

    logic [LINE_W-1:0] line_q, line_d;

    always_comb begin
        line_d = line_q;
        for (int unsigned k = 0; k < CACHE_LINE_WORDS; k++) begin
            if (strobe_i && (beat_i == BEAT_W'(k))) begin
                line_d[k*CACHE_WORD_W +: CACHE_WORD_W] = data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign line_o = line_q;

endmodule

// File: rtl/icache_refill_ctrl.sv
// I-cache miss sequencer: stalls fetch on a miss, reads the line in four in-order
// beats, then strobes the assembled line into the cache for one cycle.
module icache_refill_ctrl
    import icache_refill_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned LINE_W     = 128,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    fetch_req_i,
    input  logic [ADDR_W-1:0]       paddr_i,
    input  logic                    hit_i,
    output logic                    stall_o,
    output logic [LINE_W-1:0]       new_val_o,
    output logic                    wen_o,
    output logic                    mem_req_o,
    output logic [ADDR_W-1:0]       mem_addr_o,
    input  logic                    mem_ack_i,
    input  logic [CACHE_WORD_W-1:0] mem_data_i,
    output logic [CNT_W-1:0]        miss_cnt_o
);

    localparam int unsigned LA_W = ADDR_W - CACHE_LINE_OFF;

    state_e              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [LA_W-1:0]     line_addr_q, line_addr_d;
    logic                mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;
    logic                miss;
    logic                strobe;
    logic [BEAT_W-1:0]   beat_inc;
    logic                unused_paddr;

    assign miss         = fetch_req_i & ~hit_i;
    assign beat_inc     = beat_q + 1'b1;
    assign unused_paddr = ^paddr_i[CACHE_LINE_OFF-1:0];

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        line_addr_d = line_addr_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        miss_cnt_d  = miss_cnt_q;
        strobe      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (miss) begin
                    line_addr_d = paddr_i[ADDR_W-1:CACHE_LINE_OFF];
                    beat_d      = '0;
                    miss_cnt_d  = miss_cnt_q + CNT_W'(1);
                    mem_req_d   = 1'b1;
                    mem_addr_d  = {paddr_i[ADDR_W-1:CACHE_LINE_OFF], {BEAT_W{1'b0}}, 2'b00};
                    state_d     = StFetch;
                end
            end
            StFetch: begin
                // Request and address stay frozen until the memory acknowledges the beat.
                if (mem_ack_i) begin
                    strobe = 1'b1;
                    beat_d = beat_inc;
                    if (beat_q == BEAT_W'(LINE_WORDS - 1)) begin
                        mem_req_d = 1'b0;
                        state_d   = StFill;
                    end else begin
                        mem_addr_d = {line_addr_q, beat_inc, 2'b00};
                    end
                end
            end
            StFill: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            beat_q      <= '0;
            line_addr_q <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            line_addr_q <= line_addr_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    icache_refill_ctrl_line_assembler #(
        .LINE_W (LINE_W)
    ) u_line_assembler (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .beat_i   (beat_q),
        .strobe_i (strobe),
        .data_i   (mem_data_i),
        .line_o   (new_val_o)
    );

    // The missing fetch must not be consumed, so stall reacts in the detect cycle.
    assign stall_o    = (state_q != StIdle) | miss;
    assign wen_o      = (state_q == StFill);
    assign mem_req_o  = mem_req_q;
    assign mem_addr_o = mem_addr_q;
    assign miss_cnt_o = miss_cnt_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Bench for icache_refill_ctrl: directed scenarios, a line-level reference model,
// a one-entry cache stand-in driving Hit, and a 4-bit-counter instance for wrap.
module tb_icache_refill_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         fetch_req = 1'b0;
    logic [31:0]  paddr = 32'h0;
    logic         hit;
    logic         mem_ack = 1'b0;
    logic [31:0]  mem_data;
    logic         stall, wen, mem_req;
    logic [127:0] new_val;
    logic [31:0]  mem_addr, miss_cnt;
    logic         u4_stall, u4_wen, u4_mem_req;
    logic [127:0] u4_new_val;
    logic [31:0]  u4_mem_addr;
    logic [3:0]   u4_miss_cnt;
    int           ack_mode = 0;

    always #5 clk = ~clk;

    icache_refill_ctrl #(.ADDR_W(32), .LINE_WORDS(4), .LINE_W(128), .CNT_W(32)) dut (
        .clk_i(clk), .rst_ni(rst_n), .fetch_req_i(fetch_req), .paddr_i(paddr), .hit_i(hit),
        .stall_o(stall), .new_val_o(new_val), .wen_o(wen), .mem_req_o(mem_req),
        .mem_addr_o(mem_addr), .mem_ack_i(mem_ack), .mem_data_i(mem_data),
        .miss_cnt_o(miss_cnt)
    );

    icache_refill_ctrl #(.ADDR_W(32), .LINE_WORDS(4), .LINE_W(128), .CNT_W(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .fetch_req_i(fetch_req), .paddr_i(paddr), .hit_i(hit),
        .stall_o(u4_stall), .new_val_o(u4_new_val), .wen_o(u4_wen), .mem_req_o(u4_mem_req),
        .mem_addr_o(u4_mem_addr), .mem_ack_i(mem_ack), .mem_data_i(mem_data),
        .miss_cnt_o(u4_miss_cnt)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign mem_data = mem_word(mem_addr);

    // One-entry cache: installs the refilled line on the negedge of the write strobe.
    logic        cache_valid = 1'b0;
    logic [27:0] cache_tag = 28'h0;
    assign hit = cache_valid && (paddr[31:4] == cache_tag);

    // Reference model: refill progress as "beats received", -1 when no refill.
    int          m_beats = -1;
    logic [27:0] m_line = 28'h0;
    logic [31:0] m_cnt = 32'h0;
    logic [31:0] m_words[4];

    always @(negedge clk) begin
        if (wen) begin
            cache_valid <= 1'b1;
            cache_tag   <= m_line;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_beats <= -1;
            m_cnt   <= 32'h0;
            m_line  <= 28'h0;
        end else if (m_beats < 0) begin
            if (fetch_req && !hit) begin
                m_line  <= paddr[31:4];
                m_beats <= 0;
                m_cnt   <= m_cnt + 32'h1;
            end
        end else if (m_beats == 4) begin
            m_beats <= -1;
        end else if (mem_ack) begin
            m_words[m_beats] <= mem_word({m_line, 4'h0} + 32'(m_beats * 4));
            m_beats          <= m_beats + 1;
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Per-cycle compare plus running tallies used by the directed scenarios.
    int           cyc = 0;
    int           stall_total = 0, req_total = 0, wen_total = 0;
    int           stall_rise_cyc = 0, req_rise_cyc = 0, last_wen_cyc = 0;
    logic         prev_stall = 1'b0, prev_req = 1'b0;
    logic [127:0] last_line = '0;
    logic [31:0]  addr_q[$];

    always @(negedge clk) begin
        logic exp_req, exp_wen, exp_stall;
        exp_req   = (m_beats >= 0) && (m_beats < 4);
        exp_wen   = (m_beats == 4);
        exp_stall = (m_beats >= 0) || (fetch_req && !hit);
        chk("stall", 128'(stall), 128'(exp_stall));
        chk("mem_req", 128'(mem_req), 128'(exp_req));
        chk("wen", 128'(wen), 128'(exp_wen));
        chk("miss_cnt", 128'(miss_cnt), 128'(m_cnt));
        chk("miss_cnt4", 128'(u4_miss_cnt), 128'(m_cnt[3:0]));
        if (exp_req) chk("mem_addr", 128'(mem_addr), 128'({m_line, 4'h0} + 32'(m_beats * 4)));
        if (exp_wen) chk("new_val", new_val, {m_words[3], m_words[2], m_words[1], m_words[0]});
        cyc++;
        if (stall) stall_total++;
        if (mem_req) req_total++;
        if (stall && !prev_stall) stall_rise_cyc = cyc;
        if (mem_req && !prev_req) req_rise_cyc = cyc;
        if (mem_req && mem_ack) addr_q.push_back(mem_addr);
        if (wen) begin
            wen_total++;
            last_wen_cyc = cyc;
            last_line    = new_val;
        end
        prev_stall = stall;
        prev_req   = mem_req;
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            mem_ack = (ack_mode == 0) ? 1'b1 : ((cyc % 3) == 2);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_wen(input int target, input int budget);
        int b;
        b = budget;
        while (wen_total < target && b > 0) begin
            step(1);
            b--;
        end
        if (wen_total < target) chk("wen_timeout", 128'(wen_total), 128'(target));
    endtask

    function automatic logic [31:0] addr_at(input int idx);
        return (idx < addr_q.size()) ? addr_q[idx] : 32'hDEAD_DEAD;
    endfunction

    int s_addr, s_stall, s_req, s_wen, saved_wen_cyc, b;
    logic [31:0] exp_a[4];

    initial begin
        step(2);
        chk("rst_stall", 128'(stall), 128'(0));
        chk("rst_mem_req", 128'(mem_req), 128'(0));
        chk("rst_wen", 128'(wen), 128'(0));
        chk("rst_mem_addr", 128'(mem_addr), 128'(0));
        chk("rst_new_val", new_val, 128'(0));
        chk("rst_miss_cnt", 128'(miss_cnt), 128'(0));
        rst_n = 1'b1;
        step(1);

        // Cold miss with memory acking every cycle.
        s_addr = addr_q.size(); s_stall = stall_total; s_wen = wen_total;
        fetch_req = 1'b1; paddr = 32'h0000_1234;
        wait_wen(s_wen + 1, 20);
        step(2);
        exp_a = '{32'h1230, 32'h1234, 32'h1238, 32'h123C};
        for (int k = 0; k < 4; k++) chk("cold_addr", 128'(addr_at(s_addr + k)), 128'(exp_a[k]));
        chk("cold_stall_cycles", 128'(stall_total - s_stall), 128'(6));
        chk("cold_wen_count", 128'(wen_total - s_wen), 128'(1));
        chk("cold_wen_latency", 128'(last_wen_cyc - stall_rise_cyc), 128'(5));
        chk("cold_line", last_line, {mem_word(32'h123C), mem_word(32'h1238),
                                     mem_word(32'h1234), mem_word(32'h1230)});
        chk("cold_miss_cnt", 128'(miss_cnt), 128'(1));

        // Hits only: nothing must move.
        s_stall = stall_total; s_req = req_total; s_wen = wen_total;
        step(5);
        paddr = 32'h0000_1238;
        step(5);
        chk("hit_stall", 128'(stall_total - s_stall), 128'(0));
        chk("hit_mem_req", 128'(req_total - s_req), 128'(0));
        chk("hit_wen", 128'(wen_total - s_wen), 128'(0));
        chk("hit_miss_cnt", 128'(miss_cnt), 128'(1));

        // Slow memory: one ack every third cycle.
        ack_mode = 1;
        s_addr = addr_q.size(); s_stall = stall_total; s_wen = wen_total;
        paddr = 32'h0000_2000;
        wait_wen(s_wen + 1, 60);
        step(2);
        exp_a = '{32'h2000, 32'h2004, 32'h2008, 32'h200C};
        for (int k = 0; k < 4; k++) chk("slow_addr", 128'(addr_at(s_addr + k)), 128'(exp_a[k]));
        chk("slow_ack_count", 128'(addr_q.size() - s_addr), 128'(4));
        chk("slow_wen_count", 128'(wen_total - s_wen), 128'(1));
        chk("slow_stall_solid", 128'(stall_total - s_stall),
            128'(last_wen_cyc - stall_rise_cyc + 1));
        chk("slow_miss_cnt", 128'(miss_cnt), 128'(2));
        ack_mode = 0;

        // Redirect after beat 1: the old line still completes, then the new miss runs.
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        s_addr = addr_q.size(); s_wen = wen_total;
        paddr = 32'h0000_1234;
        b = 20;
        while (addr_q.size() - s_addr < 2 && b > 0) begin
            step(1);
            b--;
        end
        paddr = 32'h0000_8000;
        wait_wen(s_wen + 1, 20);
        saved_wen_cyc = last_wen_cyc;
        wait_wen(s_wen + 2, 20);
        step(2);
        chk("redir_addr2", 128'(addr_at(s_addr + 2)), 128'(32'h1238));
        chk("redir_addr3", 128'(addr_at(s_addr + 3)), 128'(32'h123C));
        chk("redir_new_addr0", 128'(addr_at(s_addr + 4)), 128'(32'h8000));
        chk("redir_new_addr3", 128'(addr_at(s_addr + 7)), 128'(32'h800C));
        chk("redir_idle_gap", 128'(req_rise_cyc - saved_wen_cyc), 128'(2));
        chk("redir_wen_count", 128'(wen_total - s_wen), 128'(2));
        chk("redir_miss_cnt", 128'(miss_cnt), 128'(2));

        // Reset after beat 2 abandons the refill.
        s_addr = addr_q.size(); s_wen = wen_total;
        paddr = 32'h0000_3000;
        b = 20;
        while (addr_q.size() - s_addr < 3 && b > 0) begin
            step(1);
            b--;
        end
        rst_n = 1'b0;
        fetch_req = 1'b0;
        #1;
        chk("rst_mid_mem_req", 128'(mem_req), 128'(0));
        chk("rst_mid_wen", 128'(wen), 128'(0));
        chk("rst_mid_miss_cnt", 128'(miss_cnt), 128'(0));
        chk("rst_mid_stall", 128'(stall), 128'(0));
        step(2);
        rst_n = 1'b1;
        step(3);
        chk("rst_mid_no_wen", 128'(wen_total - s_wen), 128'(0));
        chk("rst_mid_idle_req", 128'(mem_req), 128'(0));
        chk("rst_mid_idle_stall", 128'(stall), 128'(0));

        // Seventeen misses wrap the 4-bit counter to 1.
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        s_wen = wen_total;
        fetch_req = 1'b1;
        for (int i = 0; i < 17; i++) begin
            paddr = 32'h0001_0000 + 32'(i * 16);
            wait_wen(s_wen + i + 1, 20);
            step(1);
        end
        step(2);
        chk("wrap_cnt4", 128'(u4_miss_cnt), 128'(4'd1));
        chk("wrap_cnt32", 128'(miss_cnt), 128'(17));
        chk("wrap_wen_count", 128'(wen_total - s_wen), 128'(17));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
Miss-handling sequencer for the 4-way, 16-byte-line instruction cache in the IF stage. It detects a fetch miss and stalls the front end. It then reads the four words of the missing line from the memory bus, assembles them into a 128-bit line, and drives the cache's line write-enable for exactly one cycle. It also keeps a free-running miss counter for performance debug.

Parameters:
ADDR_W, 32, physical address width
LINE_WORDS, 4, 32-bit words per cache line (fixed by the cache; only 4 is supported)
LINE_W, 128, cache line width in bits (LINE_WORDS*32)
CNT_W, 32, miss counter width

Ports:
Clk  in  1  system clock; controller state changes on posedge
Rst  in  1  asynchronous reset, active-low
FetchReq  in  1  IF stage requests an instruction at PAddr this cycle
PAddr  in  ADDR_W  fetch physical address, word aligned
Hit  in  1  cache hit indication for PAddr (combinational from the cache)
Stall  out  1  freeze PC/IF; high while a miss is outstanding
NewVal  out  LINE_W  assembled line to the cache; word k occupies bits [32k+31:32k]
WEn  out  1  line write strobe to the cache; the cache samples it on negedge Clk
MemReq  out  1  memory read request
MemAddr  out  ADDR_W  word address of the current beat
MemAck  in  1  memory accepted the request and MemData is valid, sampled at posedge
MemData  in  32  read data
MissCnt  out  CNT_W  number of refills started since reset

Behaviour:
- Reset (Rst=0, asynchronous): state=IDLE; beat counter=0; line-address latch=0; NewVal=0; WEn=0; MemReq=0; MemAddr=0; MissCnt=0. Reset asserted mid-refill abandons the refill immediately; no WEn is issued.
- States: IDLE, FETCH, FILL.
- IDLE: if FetchReq=1 and Hit=0 at posedge:
  - latch LineAddr = PAddr[ADDR_W-1:4];
  - beat counter = 0;
  - MissCnt += 1 (wraps modulo 2^CNT_W);
  - go to FETCH.
- FETCH:
  - MemReq=1 and MemAddr={LineAddr, beat, 2'b00}, both registered and held stable until MemAck.
  - On posedge with MemAck=1: capture MemData into NewVal word[beat] and increment beat.
  - If beat was 3, drop MemReq and go to FILL.
  - MemAck=0 means wait indefinitely; there is no timeout.
  - Beats are always issued in order 0,1,2,3. Critical-word-first is not supported.
- FILL: WEn=1 for exactly one cycle. The cache writes on the negedge inside this cycle, and Hit is then valid for the latched line. Next state is IDLE.
- Stall = (state != IDLE) | (FetchReq & ~Hit). This is combinational, so the missing fetch is never consumed.
- Minimum miss latency with MemAck tied high: 1 (detect) + 4 (beats) + 1 (FILL) = 6 cycles of Stall. The instruction is delivered in the cycle after FILL.
- PAddr changing during FETCH or FILL (e.g. a redirect) does not abort the refill. The latched LineAddr is used throughout, and the line is still installed. Any new miss is handled after returning to IDLE.
- MemAck while in IDLE or FILL is ignored.
- NewVal holds its last value outside FILL. Its contents are don't-care when WEn=0.
- WEn is never asserted outside FILL, so the cache is never written on a hit.
- Back-to-back misses: IDLE is visited for at least one cycle between refills, and the miss check happens there.

Decomposition:
- Shared package/defines:
  - line geometry constants: CACHE_LINE_LEN, CACHE_LINE_OFF=4, words per line;
  - state encoding localparams IDLE/FETCH/FILL.
- One natural sub-module: line_assembler. It takes the beat index and the data strobe and produces the 128-bit shift/insert register. The controller FSM stays in the top.

Test Plan:
- Reset then cold miss: FetchReq=1, PAddr=0x00001234, Hit=0, MemAck=1 every cycle.
  - MemAddr sequence is 0x1230, 0x1234, 0x1238, 0x123C.
  - WEn pulses once, 5 cycles after detect.
  - NewVal = {D3,D2,D1,D0}; Stall is high for 6 cycles; MissCnt=1.
- Hit path: Hit=1, FetchReq=1 for 10 cycles -> Stall=0, MemReq=0, WEn=0, MissCnt unchanged.
- Slow memory: MemAck high only every 3rd cycle.
  - MemAddr is held stable between acks.
  - WEn fires once after the 4th ack; Stall=1 throughout.
- Redirect mid-refill: PAddr changes to 0x00008000 after beat 1 -> remaining beats still use 0x1238/0x123C and the line is installed. A new miss for 0x8000 starts after one IDLE cycle, and MissCnt=2.
- Reset mid-refill: drop Rst after beat 2 -> MemReq=0, WEn never asserted, state IDLE, MissCnt=0.
- Counter wrap: CNT_W=4, 17 misses -> MissCnt=1.
